// File: rtl/traffic_light_pkg.sv
// Shared lamp, phase, error and timing definitions for the two-road traffic light.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package traffic_light_pkg;

  // One-hot lamp codes for a single road
  typedef logic [2:0] lamp_t;
  localparam lamp_t LAMP_GREEN  = 3'b001;
  localparam lamp_t LAMP_YELLOW = 3'b010;
  localparam lamp_t LAMP_RED    = 3'b100;

  // Phase numbering of the full two-road sequence; 7 means not decodable
  typedef enum logic [2:0] {
    PH_P0      = 3'd0,  // A green,  B red
    PH_P1      = 3'd1,  // A yellow, B red
    PH_P2      = 3'd2,  // red/red after A
    PH_P3      = 3'd3,  // A red,    B green
    PH_P4      = 3'd4,  // A red,    B yellow
    PH_P5      = 3'd5,  // red/red after B
    PH_UNKNOWN = 3'd7
  } phase_e;

  // Violation codes, listed from highest to lowest priority
  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_ENC      = 3'd1,
    ERR_CONFLICT = 3'd2,
    ERR_ORDER    = 3'd3,
    ERR_SHORT    = 3'd4,
    ERR_LONG     = 3'd5
  } err_e;

  // Checker states
  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  // Default dwell lengths of the controller, in clock cycles
  localparam int DEF_GREEN_CYC  = 5;
  localparam int DEF_YELLOW_CYC = 1;
  localparam int DEF_ALLRED_CYC = 1;

  // True when a lamp code is exactly one of the three legal one-hot values
  function automatic logic lamp_legal(input lamp_t l);
    return (l == LAMP_GREEN) || (l == LAMP_YELLOW) || (l == LAMP_RED);
  endfunction

  // Phase that must follow p in a legal sequence
  function automatic logic [2:0] next_phase(input logic [2:0] p);
    case (p)
      PH_P0:   return PH_P1;
      PH_P1:   return PH_P2;
      PH_P2:   return PH_P3;
      PH_P3:   return PH_P4;
      PH_P4:   return PH_P5;
      PH_P5:   return PH_P0;
      default: return PH_UNKNOWN;
    endcase
  endfunction

endpackage

// File: rtl/traffic_phase_decoder.sv
// Decodes the two roads' lamp codes into a phase number and flags bad encodings / conflicts.
// Latency: purely combinational.
// Backpressure: none; passive decode of whatever is on the bus.
module traffic_phase_decoder
  import traffic_light_pkg::*;
(
  input  logic [2:0] a,
  input  logic [2:0] b,
  input  logic [2:0] prev_phase,
  output logic [2:0] phase,
  output logic       enc_ok,
  output logic       conflict
);

  // Red/red is ambiguous on its own; the previous phase tells which half of the cycle it belongs to
  always_comb begin
    enc_ok   = lamp_legal(a) && lamp_legal(b);
    conflict = (a != LAMP_RED) && (b != LAMP_RED);
    phase    = PH_UNKNOWN;
    case ({a, b})
      {LAMP_GREEN,  LAMP_RED}:    phase = PH_P0;
      {LAMP_YELLOW, LAMP_RED}:    phase = PH_P1;
      {LAMP_RED,    LAMP_GREEN}:  phase = PH_P3;
      {LAMP_RED,    LAMP_YELLOW}: phase = PH_P4;
      {LAMP_RED,    LAMP_RED}: begin
        if ((prev_phase == PH_P1) || (prev_phase == PH_P2))
          phase = PH_P2;
        else if ((prev_phase == PH_P4) || (prev_phase == PH_P5))
          phase = PH_P5;
        else
          phase = PH_UNKNOWN;
      end
      default: phase = PH_UNKNOWN;
    endcase
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive watchdog on the traffic light bus: phase order, dwell, encoding and conflict checks plus statistics.
// Latency: 1 cycle; a sample taken at edge t is visible on every output after edge t.
// Backpressure: none; observes every sample and never stalls the controller.
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int GREEN_CYC  = DEF_GREEN_CYC,
  parameter int YELLOW_CYC = DEF_YELLOW_CYC,
  parameter int ALLRED_CYC = DEF_ALLRED_CYC,
  parameter int CNT_W      = 4,
  parameter int ERR_W      = 8,
  parameter int CYC_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       a,
  input  logic [2:0]       b,
  output logic [2:0]       phase,
  output logic             in_sync,
  output logic             err,
  output logic [2:0]       err_code,
  output logic [ERR_W-1:0] err_count,
  output logic [CYC_W-1:0] cycles_done
);

  state_e             state_q, state_d;
  logic [2:0]         phase_q, phase_d;
  logic [CNT_W-1:0]   dwell_q, dwell_d;
  logic               partial_q, partial_d;
  logic               err_q, err_d;
  logic [2:0]         err_code_q, err_code_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;
  logic [CYC_W-1:0]   cycles_q, cycles_d;

  logic [2:0]         dec_phase;
  logic               enc_ok;
  logic               conflict;
  logic               lock_ok;
  logic               same_phase;
  logic               succ_phase;
  logic               dwell_full;
  err_e               viol;

  // Required dwell of a phase, sized to the dwell counter
  function automatic logic [CNT_W-1:0] dwell_target(input logic [2:0] p);
    case (p)
      PH_P0, PH_P3: return CNT_W'(GREEN_CYC);
      PH_P1, PH_P4: return CNT_W'(YELLOW_CYC);
      default:      return CNT_W'(ALLRED_CYC);
    endcase
  endfunction

  traffic_phase_decoder u_dec (
    .a          (a),
    .b          (b),
    .prev_phase (phase_q),
    .phase      (dec_phase),
    .enc_ok     (enc_ok),
    .conflict   (conflict)
  );

  assign lock_ok    = enc_ok && !conflict && ((dec_phase == PH_P0) || (dec_phase == PH_P3));
  assign same_phase = (dec_phase == phase_q);
  assign succ_phase = (dec_phase == next_phase(phase_q));
  assign dwell_full = (dwell_q >= dwell_target(phase_q));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_HUNT;
    else     state_q <= state_d;
  end

  // Next state: classify the sample while locked; any violation drops back to hunting
  always_comb begin
    state_d = state_q;
    viol    = ERR_NONE;
    case (state_q)
      ST_HUNT: begin
        if (lock_ok) state_d = ST_LOCK;
      end
      ST_LOCK: begin
        if (!enc_ok)                            viol = ERR_ENC;
        else if (conflict)                      viol = ERR_CONFLICT;
        else if (same_phase) begin
          if (dwell_full)                       viol = ERR_LONG;
        end
        else if (!succ_phase)                   viol = ERR_ORDER;
        else if (!partial_q && !dwell_full)     viol = ERR_SHORT;
        if (viol != ERR_NONE) state_d = ST_HUNT;
      end
      default: state_d = ST_HUNT;
    endcase
  end

  // Output / datapath next values: phase, dwell, partial flag, error reporting and statistics
  always_comb begin
    phase_d     = phase_q;
    dwell_d     = dwell_q;
    partial_d   = partial_q;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    err_count_d = err_count_q;
    cycles_d    = cycles_q;
    if (state_q == ST_HUNT) begin
      if (lock_ok) begin
        // The phase we lock into started before we saw it, so its length is unknown
        phase_d   = dec_phase;
        dwell_d   = CNT_W'(1);
        partial_d = 1'b1;
      end else begin
        phase_d   = PH_UNKNOWN;
        dwell_d   = '0;
        partial_d = 1'b0;
      end
    end else if (viol != ERR_NONE) begin
      err_d      = 1'b1;
      err_code_d = viol;
      if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
      phase_d    = PH_UNKNOWN;
      dwell_d    = '0;
      partial_d  = 1'b0;
    end else if (same_phase) begin
      if (dwell_q != '1) dwell_d = dwell_q + 1'b1;
    end else begin
      if (phase_q == PH_P5) cycles_d = cycles_q + 1'b1;
      phase_d   = dec_phase;
      dwell_d   = CNT_W'(1);
      partial_d = 1'b0;
    end
  end

  // Datapath and statistics registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q     <= PH_UNKNOWN;
      dwell_q     <= '0;
      partial_q   <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      err_count_q <= '0;
      cycles_q    <= '0;
    end else begin
      phase_q     <= phase_d;
      dwell_q     <= dwell_d;
      partial_q   <= partial_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      err_count_q <= err_count_d;
      cycles_q    <= cycles_d;
    end
  end

  assign phase       = phase_q;
  assign in_sync     = (state_q == ST_LOCK);
  assign err         = err_q;
  assign err_code    = err_code_q;
  assign err_count   = err_count_q;
  assign cycles_done = cycles_q;

endmodule
